// File: rtl/quick_rs232_tx_feeder_if.sv
// quick_rs232_tx_feeder_if
//   Handshake between the byte feeder and the quick_rs232 transmitter.
//   master : the feeder (drives transaction/data/ready, observes copied/busy)
//   slave  : the transmitter
// Signals:
//   tx_transaction  feeder -> tx  : keep the line owned between bytes
//   tx_data[7:0]    feeder -> tx  : byte on offer
//   tx_data_ready   feeder -> tx  : tx_data is valid
//   tx_data_copied  tx -> feeder  : one-cycle pulse, byte taken
//   tx_busy         tx -> feeder  : transmitter still shifting
interface quick_rs232_tx_feeder_if;
    logic       tx_transaction;
    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       tx_data_copied;
    logic       tx_busy;

    modport master (
        output tx_transaction,
        output tx_data,
        output tx_data_ready,
        input  tx_data_copied,
        input  tx_busy
    );

    modport slave (
        input  tx_transaction,
        input  tx_data,
        input  tx_data_ready,
        output tx_data_copied,
        output tx_busy
    );
endinterface

// File: rtl/quick_rs232_tx_feeder.sv
// quick_rs232_tx_feeder
//   Power-of-two byte FIFO feeding the quick_rs232 transmitter handshake so that
//   bursts of writes become a back-to-back serial stream. tx_transaction is held
//   across short gaps and released IDLE_TIMEOUT clocks after the FIFO drains and
//   the transmitter is no longer busy.
// Parameters:
//   DEPTH         FIFO entries (power of two, >= 2)
//   IDLE_TIMEOUT  clocks tx_transaction lingers after draining (0 = drop at once)
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   wr_en/wr_data one byte per cycle write port; dropped when full
//   full, level   decoded from the registered occupancy count
//   tx            quick_rs232_tx_feeder_if.master handshake to the transmitter
//   overflow, overflow_clr  sticky write-while-full flag and its clear; present
//                 only when QUICK_RS232_TX_FEEDER_OVERFLOW_EN is defined
module quick_rs232_tx_feeder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned IDLE_TIMEOUT = 4340
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [7:0]                wr_data,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    quick_rs232_tx_feeder_if.master   tx
`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
    ,
    output logic                      overflow,
    input  logic                      overflow_clr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Width large enough to hold IDLE_TIMEOUT; at least one bit.
    localparam int unsigned TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StGap,
        StLinger
    } state_e;

    state_e          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   idle_cnt;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push = wr_en && !full;
    // Every state except OFFER takes the head byte as soon as one is available.
    assign pop  = !empty && (state != StOffer);

    // Storage is not reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= StIdle;
            tx.tx_transaction <= 1'b0;
            tx.tx_data_ready  <= 1'b0;
            tx.tx_data        <= 8'h00;
            idle_cnt          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        tx.tx_data        <= mem[rd_ptr];
                        tx.tx_data_ready  <= 1'b1;
                        tx.tx_transaction <= 1'b1;
                        state             <= StOffer;
                    end
                end
                StOffer: begin
                    if (tx.tx_data_copied) begin
                        tx.tx_data_ready <= 1'b0;
                        state            <= StGap;
                    end
                end
                StGap: begin
                    if (pop) begin
                        tx.tx_data       <= mem[rd_ptr];
                        tx.tx_data_ready <= 1'b1;
                        state            <= StOffer;
                    end else begin
                        idle_cnt <= TW'(IDLE_TIMEOUT);
                        state    <= StLinger;
                    end
                end
                StLinger: begin
                    if (pop) begin
                        tx.tx_data       <= mem[rd_ptr];
                        tx.tx_data_ready <= 1'b1;
                        state            <= StOffer;
                    end else if (idle_cnt == '0 && !tx.tx_busy) begin
                        tx.tx_transaction <= 1'b0;
                        state             <= StIdle;
                    end else if (idle_cnt != '0) begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
    // Set has priority over clear so a concurrent event is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_quick_rs232_tx_feeder.sv
// Directed bench for quick_rs232_tx_feeder with a byte scoreboard.
module tb_quick_rs232_tx_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned T     = 12;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [4:0]  level;
`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
    logic        overflow;
    logic        overflow_clr;
`endif

    quick_rs232_tx_feeder_if tx_if ();

    quick_rs232_tx_feeder #(
        .DEPTH        (DEPTH),
        .IDLE_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .level        (level),
        .tx           (tx_if.master)
`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
        ,
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge passes; returns at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit drop);
        wr_data = d;
        wr_en   = 1'b1;
        if (!drop) exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    // Transmitter model: wait for an offer, compare it, pulse copied.
    task automatic xmit(input bit hold);
        int n;
        logic [7:0] exp;
        n = 0;
        while (tx_if.tx_data_ready !== 1'b1 && n < 40) begin
            if (hold) chk("trans_hold", tx_if.tx_transaction, 1);
            step();
            n++;
        end
        chk("offer_seen", tx_if.tx_data_ready, 1);
        if (tx_if.tx_data_ready === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_data", tx_if.tx_data, exp);
            chk("trans_offer", tx_if.tx_transaction, 1);
            tx_if.tx_data_copied = 1'b1;
            step();
            tx_if.tx_data_copied = 1'b0;
            chk("ready_drop", tx_if.tx_data_ready, 0);
        end
    endtask

    task automatic wait_drop();
        int n;
        n = 0;
        while (tx_if.tx_transaction === 1'b1 && n < int'(T) + 10) begin
            step();
            n++;
        end
        chk("trans_released", tx_if.tx_transaction, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b0;
        wr_en                = 1'b1;
        wr_data              = 8'hFF;
        tx_if.tx_data_copied = 1'b0;
        tx_if.tx_busy        = 1'b0;
`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
        overflow_clr         = 1'b0;
`endif
        // Reset held with writes active.
        repeat (5) step();
        chk("rst_trans", tx_if.tx_transaction, 0);
        chk("rst_ready", tx_if.tx_data_ready, 0);
        chk("rst_data", tx_if.tx_data, 8'h00);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
        chk("rst_ovf", overflow, 0);
`endif
        rst   = 1'b1;
        wr_en = 1'b0;
        step();

        // Single byte: latency, handshake, linger timeout.
        wr_byte(8'h8C, 0);
        chk("single_level1", level, 1);
        chk("single_ready_early", tx_if.tx_data_ready, 0);
        step();
        chk("single_ready", tx_if.tx_data_ready, 1);
        chk("single_trans", tx_if.tx_transaction, 1);
        chk("single_level0", level, 0);
        xmit(0);
        step();                      // GAP edge
        repeat (T) step();
        chk("linger_hold", tx_if.tx_transaction, 1);
        step();
        chk("linger_drop", tx_if.tx_transaction, 0);

        // Burst while a byte is parked in OFFER: fills FIFO, extra byte dropped.
        wr_byte(8'hF0, 0);
        step();
        chk("burst_offer", tx_if.tx_data_ready, 1);
        for (int i = 1; i <= 16; i++) wr_byte(8'(i), 0);
        chk("burst_full", full, 1);
        chk("burst_level", level, 16);
        wr_byte(8'hAA, 1);
        chk("drop_full", full, 1);
        chk("drop_level", level, 16);
        tx_if.tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) xmit(1);
        chk("burst_empty", level, 0);
        repeat (T + 5) step();
        chk("busy_hold", tx_if.tx_transaction, 1);
        tx_if.tx_busy = 1'b0;
        step();
        chk("busy_release", tx_if.tx_transaction, 0);

        // Write during LINGER mid-count.
        wr_byte(8'h33, 0);
        xmit(0);
        step();                      // GAP edge
        repeat (4) step();
        chk("mid_linger", tx_if.tx_transaction, 1);
        wr_byte(8'h55, 0);
        chk("mid_linger_trans", tx_if.tx_transaction, 1);
        xmit(1);
        wait_drop();

        // Reset during OFFER with three bytes queued.
        wr_byte(8'h61, 0);
        wr_byte(8'h62, 0);
        wr_byte(8'h63, 0);
        wr_byte(8'h64, 0);
        chk("pre_rst_level", level, 3);
        chk("pre_rst_ready", tx_if.tx_data_ready, 1);
        chk("pre_rst_data", tx_if.tx_data, 8'h61);
        rst = 1'b0;
        step();
        chk("mid_rst_ready", tx_if.tx_data_ready, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_trans", tx_if.tx_transaction, 0);
        chk("mid_rst_data", tx_if.tx_data, 8'h00);
        exp_q.delete();
        rst = 1'b1;
        repeat (10) step();
        chk("post_rst_ready", tx_if.tx_data_ready, 0);
        chk("post_rst_level", level, 0);

`ifdef QUICK_RS232_TX_FEEDER_OVERFLOW_EN
        // Overflow flag: set, clear, set wins over clear.
        for (int i = 0; i < 17; i++) wr_byte(8'(8'h80 + i), 0);
        chk("ovf_full", full, 1);
        chk("ovf_none_yet", overflow, 0);
        wr_byte(8'hEE, 1);
        chk("ovf_set", overflow, 1);
        overflow_clr = 1'b1;
        step();
        chk("ovf_clr", overflow, 0);
        wr_byte(8'hEF, 1);
        chk("ovf_set_wins", overflow, 1);
        step();
        overflow_clr = 1'b0;
        chk("ovf_clr2", overflow, 0);
        for (int i = 0; i < 17; i++) xmit(1);
        wait_drop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
